// File: rtl/row_event_packetizer.sv
// row_event_packetizer
// Stamps each granted row event with a free-running timestamp, packs it as
// {ts, xadd, yadd, pol} and buffers it in a first-word-fall-through FIFO that
// is drained over a valid/ready interface. It also throttles the row arbiter
// through arb_enable_o and issues the group refresh pulse that re-arms the
// arbiter mask.
//
// Ports:
//   clk_i, reset_i        clock; asynchronous active-high reset
//   gnt_row_i, xadd_i     registered one-hot row grant and its encoded address
//   yadd_i, polarity_i    column address and polarity, qualified by col_vld_i
//   grp_release_i         arbiter reports no masked requests left
//   arb_enable_o          enable to the row arbiter (registered)
//   refresh_o             one-cycle mask refresh pulse
//   evt_data_o/valid_o    FIFO head packet, evt_ready_i accepts it
//   fifo_full_o/empty_o   FIFO occupancy flags
//   overflow_o            sticky: an event was dropped on a full FIFO
module row_event_packetizer #(
  parameter int Lvl_ROWS    = 4,
  parameter int Lvl_ROW_ADD = 2,
  parameter int Lvl_COL_ADD = 2,
  parameter int TS_WIDTH    = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic [Lvl_ROWS-1:0]                             gnt_row_i,
  input  logic [Lvl_ROW_ADD-1:0]                          xadd_i,
  input  logic [Lvl_COL_ADD-1:0]                          yadd_i,
  input  logic                                            col_vld_i,
  input  logic                                            polarity_i,
  input  logic                                            grp_release_i,
  output logic                                            arb_enable_o,
  output logic                                            refresh_o,
  output logic [TS_WIDTH+Lvl_ROW_ADD+Lvl_COL_ADD+1-1:0]   evt_data_o,
  output logic                                            evt_valid_o,
  input  logic                                            evt_ready_i,
  output logic                                            fifo_full_o,
  output logic                                            fifo_empty_o,
  output logic                                            overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PKT_W = TS_WIDTH + Lvl_ROW_ADD + Lvl_COL_ADD + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [TS_WIDTH-1:0] ts_cnt_r;
  logic [PKT_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_next_s;
  logic                capture_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic [PKT_W-1:0]    pkt_s;
  logic                arb_enable_r;
  logic                overflow_r;
  state_t              state_r;
  state_t              state_next_s;

  assign capture_s = (|gnt_row_i) & col_vld_i;
  assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  // A pop in the same cycle never makes room for a push into a full FIFO.
  assign push_s    = capture_s & ~full_s;
  assign pop_s     = ~empty_s & evt_ready_i;
  assign pkt_s     = {ts_cnt_r, xadd_i, yadd_i, polarity_i};

  // Occupancy after this edge.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Timestamp, FIFO pointers/count, arbiter enable and sticky overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_cnt_r     <= {TS_WIDTH{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      arb_enable_r <= 1'b1;
      overflow_r   <= 1'b0;
    end else begin
      ts_cnt_r <= ts_cnt_r + TS_WIDTH'(1);
      count_r  <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      // Keep one slot free for the grant already held in the arbiter register.
      arb_enable_r <= (count_next_s <= CNT_W'(FIFO_DEPTH - 2));
      if (capture_s & full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are invalidated by the pointer/count reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pkt_s;
    end
  end

  // Refresh FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Refresh FSM next state; IDLE ignores grp_release_i so no refresh happens
  // without a prior event.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (push_s) state_next_s = SCAN;
        else        state_next_s = IDLE;
      end
      SCAN: begin
        if (grp_release_i & ~capture_s) state_next_s = RELEASE;
        else                            state_next_s = SCAN;
      end
      RELEASE: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign refresh_o    = (state_r == RELEASE);
  assign arb_enable_o = arb_enable_r;
  assign overflow_o   = overflow_r;
  assign fifo_full_o  = full_s;
  assign fifo_empty_o = empty_s;
  assign evt_valid_o  = ~empty_s;
  // Forced to zero when empty so the output matches its reset value.
  assign evt_data_o   = empty_s ? {PKT_W{1'b0}} : mem_r[rd_ptr_r];

endmodule

// File: tb/tb_row_event_packetizer.sv
module tb_row_event_packetizer;

  logic        clk;
  logic        reset_i;
  logic [3:0]  gnt_row_i;
  logic [1:0]  xadd_i;
  logic [1:0]  yadd_i;
  logic        col_vld_i;
  logic        polarity_i;
  logic        grp_release_i;
  logic        evt_ready_i;

  logic        arb_enable_o, refresh_o, evt_valid_o, fifo_full_o, fifo_empty_o, overflow_o;
  logic [20:0] evt_data_o;

  logic        arb_enable4, refresh4, evt_valid4, fifo_full4, fifo_empty4, overflow4;
  logic [8:0]  evt_data4;

  int n_cmp = 0;
  int n_err = 0;

  row_event_packetizer dut (
    .clk_i(clk), .reset_i(reset_i), .gnt_row_i(gnt_row_i), .xadd_i(xadd_i),
    .yadd_i(yadd_i), .col_vld_i(col_vld_i), .polarity_i(polarity_i),
    .grp_release_i(grp_release_i), .arb_enable_o(arb_enable_o), .refresh_o(refresh_o),
    .evt_data_o(evt_data_o), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o), .overflow_o(overflow_o)
  );

  row_event_packetizer #(.TS_WIDTH(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .gnt_row_i(gnt_row_i), .xadd_i(xadd_i),
    .yadd_i(yadd_i), .col_vld_i(col_vld_i), .polarity_i(polarity_i),
    .grp_release_i(grp_release_i), .arb_enable_o(arb_enable4), .refresh_o(refresh4),
    .evt_data_o(evt_data4), .evt_valid_o(evt_valid4), .evt_ready_i(evt_ready_i),
    .fifo_full_o(fifo_full4), .fifo_empty_o(fifo_empty4), .overflow_o(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cap(input logic [1:0] x, input logic [1:0] y, input logic p);
    gnt_row_i  = 4'b0001 << x;
    xadd_i     = x;
    yadd_i     = y;
    polarity_i = p;
    col_vld_i  = 1'b1;
  endtask

  task automatic clr_cap();
    gnt_row_i  = 4'b0000;
    xadd_i     = 2'd0;
    yadd_i     = 2'd0;
    polarity_i = 1'b0;
    col_vld_i  = 1'b0;
  endtask

  // Leaves the bench at a negedge with reset released; the next posedge is edge 0.
  task automatic do_reset();
    reset_i       = 1'b1;
    clr_cap();
    grp_release_i = 1'b0;
    evt_ready_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #1;
    n_cmp++; if (evt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", evt_valid_o); end
    n_cmp++; if (evt_data_o !== 21'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", evt_data_o); end
    n_cmp++; if ({fifo_full_o, fifo_empty_o} !== 2'b01) begin n_err++; $display("FAIL reset_flags got=%b exp=01", {fifo_full_o, fifo_empty_o}); end
    n_cmp++; if ({arb_enable_o, refresh_o, overflow_o} !== 3'b100) begin n_err++; $display("FAIL reset_ctrl got=%b exp=100", {arb_enable_o, refresh_o, overflow_o}); end
  endtask

  task automatic test_single_event();
    do_reset();
    evt_ready_i = 1'b1;
    repeat (5) step();
    set_cap(2'd2, 2'd1, 1'b1);
    step();                      // edge 5: push
    clr_cap();
    n_cmp++; if (evt_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", evt_valid_o); end
    n_cmp++; if (evt_data_o !== {16'd5, 2'd2, 2'd1, 1'b1}) begin n_err++; $display("FAIL single_data got=%h exp=%h", evt_data_o, {16'd5, 2'd2, 2'd1, 1'b1}); end
    step();                      // edge 6: pop
    n_cmp++; if (fifo_empty_o !== 1'b1 || evt_valid_o !== 1'b0) begin n_err++; $display("FAIL single_popped empty=%b valid=%b exp=1/0", fifo_empty_o, evt_valid_o); end
  endtask

  task automatic test_fill_drain();
    logic [20:0] exp_pkt [8];
    logic [1:0]  xi;
    do_reset();
    evt_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      xi = 2'(i);
      if (i < 8) exp_pkt[i] = {16'(i), xi, ~xi, xi[0]};
      set_cap(xi, ~xi, xi[0]);
      step();                    // edge i, ts == i
      if (i == 5) begin
        n_cmp++; if (arb_enable_o !== 1'b1) begin n_err++; $display("FAIL fill_arb6 got=%b exp=1", arb_enable_o); end
      end else if (i == 6) begin
        n_cmp++; if (arb_enable_o !== 1'b0) begin n_err++; $display("FAIL fill_arb7 got=%b exp=0", arb_enable_o); end
        n_cmp++; if (fifo_full_o !== 1'b0) begin n_err++; $display("FAIL fill_full7 got=%b exp=0", fifo_full_o); end
      end else if (i == 7) begin
        n_cmp++; if (fifo_full_o !== 1'b1) begin n_err++; $display("FAIL fill_full8 got=%b exp=1", fifo_full_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fill_ovf8 got=%b exp=0", overflow_o); end
      end else if (i == 8) begin
        n_cmp++; if (overflow_o !== 1'b1 || fifo_full_o !== 1'b1) begin n_err++; $display("FAIL fill_ovf9 ovf=%b full=%b exp=1/1", overflow_o, fifo_full_o); end
      end
    end
    clr_cap();
    evt_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_cmp++; if (evt_valid_o !== 1'b1 || evt_data_o !== exp_pkt[j]) begin n_err++; $display("FAIL drain_pkt%0d got=%h valid=%b exp=%h", j, evt_data_o, evt_valid_o, exp_pkt[j]); end
      step();
      if (j == 0) begin
        n_cmp++; if (arb_enable_o !== 1'b0) begin n_err++; $display("FAIL drain_arb7 got=%b exp=0", arb_enable_o); end
      end else if (j == 1) begin
        n_cmp++; if (arb_enable_o !== 1'b1) begin n_err++; $display("FAIL drain_arb6 got=%b exp=1", arb_enable_o); end
      end
    end
    n_cmp++; if (fifo_empty_o !== 1'b1 || overflow_o !== 1'b1) begin n_err++; $display("FAIL drain_end empty=%b ovf=%b exp=1/1", fifo_empty_o, overflow_o); end
  endtask

  task automatic test_push_pop();
    logic [20:0] exp_pkt [4];
    logic [1:0]  xi;
    do_reset();
    evt_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xi = 2'(i);
      exp_pkt[i] = {16'(i), xi, xi, 1'b1};
      set_cap(xi, xi, 1'b1);
      if (i == 3) evt_ready_i = 1'b1;   // edge 3: push and pop at count 3
      step();
    end
    clr_cap();
    for (int j = 1; j < 4; j++) begin
      n_cmp++; if (evt_valid_o !== 1'b1 || evt_data_o !== exp_pkt[j]) begin n_err++; $display("FAIL pushpop_pkt%0d got=%h valid=%b exp=%h", j, evt_data_o, evt_valid_o, exp_pkt[j]); end
      step();
    end
    n_cmp++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL pushpop_count empty=%b exp=1", fifo_empty_o); end
  endtask

  task automatic test_refresh();
    do_reset();
    evt_ready_i = 1'b1;
    set_cap(2'd1, 2'd0, 1'b0);
    step();                      // edge 0: IDLE -> SCAN
    set_cap(2'd3, 2'd2, 1'b1);
    grp_release_i = 1'b1;
    step();                      // edge 1: capture keeps SCAN
    clr_cap();
    n_cmp++; if (refresh_o !== 1'b0) begin n_err++; $display("FAIL refresh_early got=%b exp=0", refresh_o); end
    step();                      // edge 2: SCAN -> RELEASE
    n_cmp++; if (refresh_o !== 1'b1) begin n_err++; $display("FAIL refresh_pulse got=%b exp=1", refresh_o); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (refresh_o !== 1'b0) begin n_err++; $display("FAIL refresh_idle%0d got=%b exp=0", k, refresh_o); end
    end
    set_cap(2'd0, 2'd3, 1'b1);
    step();                      // IDLE -> SCAN again
    clr_cap();
    n_cmp++; if (refresh_o !== 1'b0) begin n_err++; $display("FAIL refresh_rearm0 got=%b exp=0", refresh_o); end
    step();                      // SCAN -> RELEASE
    n_cmp++; if (refresh_o !== 1'b1) begin n_err++; $display("FAIL refresh_rearm1 got=%b exp=1", refresh_o); end
    grp_release_i = 1'b0;
  endtask

  task automatic test_ts_wrap();
    do_reset();
    evt_ready_i = 1'b0;
    repeat (15) step();
    set_cap(2'd1, 2'd2, 1'b1);
    step();                      // edge 15
    set_cap(2'd2, 2'd3, 1'b0);
    step();                      // edge 16
    clr_cap();
    n_cmp++; if (evt_data4 !== {4'd15, 2'd1, 2'd2, 1'b1}) begin n_err++; $display("FAIL wrap_ts15 got=%h exp=%h", evt_data4, {4'd15, 2'd1, 2'd2, 1'b1}); end
    evt_ready_i = 1'b1;
    step();
    n_cmp++; if (evt_data4 !== {4'd0, 2'd2, 2'd3, 1'b0}) begin n_err++; $display("FAIL wrap_ts0 got=%h exp=%h", evt_data4, {4'd0, 2'd2, 2'd3, 1'b0}); end
    n_cmp++; if (evt_data_o !== {16'd16, 2'd2, 2'd3, 1'b0}) begin n_err++; $display("FAIL wrap_wide got=%h exp=%h", evt_data_o, {16'd16, 2'd2, 2'd3, 1'b0}); end
    evt_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    evt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cap(2'(i), 2'd1, 1'b1);
      step();
    end
    clr_cap();
    n_cmp++; if (evt_valid_o !== 1'b1) begin n_err++; $display("FAIL areset_pre got=%b exp=1", evt_valid_o); end
    #1;
    reset_i = 1'b1;              // between clock edges
    #1;
    n_cmp++; if ({evt_valid_o, fifo_full_o, fifo_empty_o} !== 3'b001) begin n_err++; $display("FAIL areset_flags got=%b exp=001", {evt_valid_o, fifo_full_o, fifo_empty_o}); end
    n_cmp++; if (evt_data_o !== 21'd0) begin n_err++; $display("FAIL areset_data got=%h exp=0", evt_data_o); end
    n_cmp++; if ({arb_enable_o, refresh_o, overflow_o} !== 3'b100) begin n_err++; $display("FAIL areset_ctrl got=%b exp=100", {arb_enable_o, refresh_o, overflow_o}); end
  endtask

  initial begin
    reset_i = 1'b1;
    clr_cap();
    grp_release_i = 1'b0;
    evt_ready_i   = 1'b0;
    test_reset();
    test_single_event();
    test_fill_drain();
    test_push_pop();
    test_refresh();
    test_ts_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
